// File: rtl/neuron_feeder_pkg.sv
// Shared definitions for the neuron feeder: Q8.24 constants, config
// register addresses and the feeder FSM encoding.
package neuron_feeder_pkg;

  localparam int FBITS = 24;
  localparam logic [31:0] Q_ONE = 32'd1 << FBITS;

  localparam logic [1:0] CFG_W1   = 2'd0;
  localparam logic [1:0] CFG_W2   = 2'd1;
  localparam logic [1:0] CFG_W3   = 2'd2;
  localparam logic [1:0] CFG_BIAS = 2'd3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/neuron_feeder_if.sv
// Stream-in, stream-out and config bus of the neuron feeder.
// Handshakes: a transfer completes on a rising edge where valid & ready
// (and the block enable) are high; valid never waits on ready.
interface neuron_feeder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err
  );
endinterface

// File: rtl/neuron_feeder_fifo_sync.sv
// Synchronous FIFO with power-of-two depth; head is presented combinationally.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/neuron_feeder.sv
// Groups serial activations into triples, fires them at the neuron with
// stored weights/bias, and collects results into a credit-protected FIFO.
module neuron_feeder
  import neuron_feeder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NEURON_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  neuron_feeder_if.slave   bus,
  output logic             n_en,
  output logic [WIDTH-1:0] n_a1,
  output logic [WIDTH-1:0] n_a2,
  output logic [WIDTH-1:0] n_a3,
  output logic [WIDTH-1:0] n_w1,
  output logic [WIDTH-1:0] n_w2,
  output logic [WIDTH-1:0] n_w3,
  output logic [WIDTH-1:0] n_b,
  input  logic [WIDTH-1:0] n_y,
  output state_t           dbg_state
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(NEURON_LAT + 1);

  state_t                  state;
  logic [1:0]              idx;
  logic [NEURON_LAT-1:0]   tracker;
  logic [INF_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [31:0]             credit_sum;
  logic                    fire;
  logic                    push;
  logic                    pop;
  logic                    cfg_ok;

  assign n_en          = en;
  assign dbg_state     = state;
  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = !fifo_empty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NEURON_LAT; i++) inflight = inflight + INF_W'(tracker[i]);
  end

  // Credit counts results still in the neuron pipe; a pop this cycle is not credited.
  assign credit_sum = 32'(fifo_count) + 32'(inflight);
  assign fire       = en && (state == HOLD) && (credit_sum < 32'(FIFO_DEPTH));
  assign push       = en && tracker[NEURON_LAT-1];
  assign pop        = en && bus.out_valid && bus.out_ready;
  assign cfg_ok     = (inflight == '0) && (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      idx         <= 2'd0;
      tracker     <= '0;
      n_a1        <= '0;
      n_a2        <= '0;
      n_a3        <= '0;
      n_w1        <= WIDTH'(Q_ONE);
      n_w2        <= WIDTH'(Q_ONE);
      n_w3        <= WIDTH'(Q_ONE);
      n_b         <= '0;
      bus.cfg_err <= 1'b0;
    end else begin
      assert (!(push && fifo_full));
      bus.cfg_err <= bus.cfg_we && !cfg_ok;
      // Config writes ignore en; weights must not move under an in-flight triple.
      if (bus.cfg_we && cfg_ok) begin
        case (bus.cfg_addr)
          CFG_W1:   n_w1 <= bus.cfg_data;
          CFG_W2:   n_w2 <= bus.cfg_data;
          CFG_W3:   n_w3 <= bus.cfg_data;
          CFG_BIAS: n_b  <= bus.cfg_data;
          default:  ;
        endcase
      end
      if (en) begin
        tracker <= (tracker << 1) | NEURON_LAT'(fire);
        case (state)
          FILL: begin
            if (bus.in_valid) begin
              case (idx)
                2'd0:    n_a1 <= bus.in_data;
                2'd1:    n_a2 <= bus.in_data;
                default: n_a3 <= bus.in_data;
              endcase
              if (idx == 2'd2) begin
                state <= HOLD;
                idx   <= 2'd0;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end
          HOLD: if (fire) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (n_y),
    .dout  (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: a hard-sigmoid neuron stand-in, a triple-level
// reference model with an expected-result queue, and directed scenarios.
module tb_neuron_feeder;
  import neuron_feeder_pkg::*;

  localparam int W     = 32;
  localparam int LAT   = 3;   // one longer than default so a result can be caught in flight
  localparam int DEPTH = 4;
  localparam logic [W-1:0] HALF = 32'h0080_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  neuron_feeder_if #(.WIDTH(W)) bus();
  logic         n_en;
  logic [W-1:0] n_a1, n_a2, n_a3, n_w1, n_w2, n_w3, n_b, n_y;
  state_t       dbg_state;

  neuron_feeder #(.WIDTH(W), .NEURON_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .n_en(n_en), .n_a1(n_a1), .n_a2(n_a2), .n_a3(n_a3),
    .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3), .n_b(n_b),
    .n_y(n_y), .dbg_state(dbg_state)
  );

  // Hard sigmoid: clamp(0.5 + z/4, 0, 1), z = sum(a*w) + b in Q8.24.
  function automatic logic [W-1:0] hsig(input logic [W-1:0] a1, a2, a3, w1, w2, w3, b);
    longint z;
    z = (longint'($signed(a1)) * longint'($signed(w1)) +
         longint'($signed(a2)) * longint'($signed(w2)) +
         longint'($signed(a3)) * longint'($signed(w3))) >>> FBITS;
    z = z + longint'($signed(b));
    z = 64'sh0080_0000 + (z >>> 2);
    if (z < 0) z = 0;
    if (z > 64'sh0100_0000) z = 64'sh0100_0000;
    return W'(z);
  endfunction

  // Neuron stand-in: samples a/w/b on every enabled edge, y after LAT edges.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (n_en) begin
      pipe[0] <= hsig(n_a1, n_a2, n_a3, n_w1, n_w2, n_w3, n_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign n_y = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  logic [W-1:0] m_w [3] = '{Q_ONE, Q_ONE, Q_ONE};
  logic [W-1:0] m_b = '0;
  logic [W-1:0] part [3];
  int part_n  = 0;
  int accepts = 0;
  int results = 0;
  int checks  = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every transfer is judged mid-cycle, ahead of the edge that completes it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        part_n = 0;
        m_w = '{Q_ONE, Q_ONE, Q_ONE};
        m_b = '0;
      end else if (en) begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", bus.out_data);
          end else begin
            check("result", bus.out_data, exp_q.pop_front());
          end
          results++;
        end
        if (bus.in_valid && bus.in_ready) begin
          part[part_n] = bus.in_data;
          part_n++;
          accepts++;
          if (part_n == 3) begin
            exp_q.push_back(hsig(part[0], part[1], part[2], m_w[0], m_w[1], m_w[2], m_b));
            part_n = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int t;
    bit done;
    t = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!done && t < 300) begin
      @(negedge clk);
      if (bus.in_ready && en) done = 1;
      else t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] d, input bit ok);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
    check("cfg_err", W'(bus.cfg_err), W'(!ok));
    if (ok) begin
      if (a == CFG_BIAS) m_b = d;
      else m_w[a] = d;
    end
  endtask

  task automatic wait_valid(input int max);
    int t;
    t = 0;
    while (!bus.out_valid && t < max) begin
      tick();
      t++;
    end
    check("out_valid_wait", W'(bus.out_valid), W'(1));
  endtask

  task automatic wait_drain(input int max);
    int t;
    t = 0;
    while ((exp_q.size() != 0) && t < max) begin
      tick();
      t++;
    end
    check("drain_left", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] vec(input int i);
    logic [W-1:0] vals [8];
    vals = '{32'h0100_0000, 32'hFF80_0000, 32'h0040_0000, 32'h0200_0000,
             32'hFE00_0000, 32'h0000_0000, 32'h0180_0000, 32'hFFC0_0000};
    return vals[i % 8] + (W'(i) << 12);
  endfunction

  bit en_rand = 1'b0;

  // ---------------- stimulus ----------------
  initial begin
    int acc0;
    int res0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    do_reset();

    // Reset state
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_cfg_err", W'(bus.cfg_err), W'(0));
    check("rst_n_a", n_a1 | n_a2 | n_a3, '0);
    check("rst_n_w1", n_w1, Q_ONE);
    check("rst_n_w2", n_w2, Q_ONE);
    check("rst_n_w3", n_w3, Q_ONE);
    check("rst_n_b", n_b, '0);
    check("rst_state", W'(dbg_state), W'(FILL));
    check("n_en", W'(n_en), W'(1));

    // Default weights, 0,0,0: fire one edge after the third accept, push LAT edges later
    send('0); send('0); send('0);
    check("hold_in_ready", W'(bus.in_ready), W'(0));
    check("hold_state", W'(dbg_state), W'(HOLD));
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == 1) check("refill_in_ready", W'(bus.in_ready), W'(1));
      if (k == LAT) check("out_valid_early", W'(bus.out_valid), W'(0));
      if (k == LAT + 1) begin
        check("out_valid_rise", W'(bus.out_valid), W'(1));
        check("default_result", bus.out_data, HALF);
      end
    end
    bus.out_ready = 1'b1;
    wait_drain(50);

    // Configure w=1,1,1 b=-1, feed 1,0,0; a bias write while in flight is dropped
    bus.out_ready = 1'b0;
    cfg_write(CFG_W1, Q_ONE, 1'b1);
    cfg_write(CFG_W2, Q_ONE, 1'b1);
    cfg_write(CFG_W3, Q_ONE, 1'b1);
    cfg_write(CFG_BIAS, 32'hFF00_0000, 1'b1);
    check("cfg_n_b", n_b, 32'hFF00_0000);
    send(Q_ONE); send('0); send('0);
    tick();
    cfg_write(CFG_BIAS, 32'h0000_0000, 1'b0);
    tick();
    check("cfg_err_pulse_end", W'(bus.cfg_err), W'(0));
    check("cfg_n_b_kept", n_b, 32'hFF00_0000);
    wait_valid(20);
    check("cfg_result", bus.out_data, HALF);
    bus.out_ready = 1'b1;
    wait_drain(50);

    // Working weights for the streaming scenarios
    cfg_write(CFG_W1, 32'h0080_0000, 1'b1);
    cfg_write(CFG_W2, 32'hFFC0_0000, 1'b1);
    cfg_write(CFG_W3, 32'h0200_0000, 1'b1);
    cfg_write(CFG_BIAS, 32'h0020_0000, 1'b1);

    // Backpressure: four results fill the FIFO, the fifth triple waits in HOLD
    bus.out_ready = 1'b0;
    acc0 = accepts;
    res0 = results;
    fork
      begin
        for (int i = 0; i < 24; i++) send(vec(i));
      end
      begin
        repeat (60) tick();
        check("bp_accepts", W'(accepts - acc0), W'(15));
        check("bp_in_ready", W'(bus.in_ready), W'(0));
        check("bp_state", W'(dbg_state), W'(HOLD));
        check("bp_out_valid", W'(bus.out_valid), W'(1));
        check("bp_pending", W'(exp_q.size()), W'(5));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain(100);
    check("bp_results", W'(results - res0), W'(8));

    // FIFO near full, then continuous draining while pushes continue
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(vec(i + 5));
    repeat (12) tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(vec(i + 17));
    wait_drain(100);

    // Random enable while streaming
    en_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 15; i++) send(vec(3 * i + 1));
        en_rand = 1'b0;
      end
      begin
        while (en_rand) begin
          en = ($urandom_range(0, 3) != 0);
          tick();
        end
        en = 1'b1;
      end
    join
    wait_drain(200);

    // Reset with two samples collected and one result still in the neuron
    send(vec(2)); send(vec(3)); send(vec(4));
    send(vec(5)); send(vec(6));
    do_reset();
    check("mid_rst_out_valid", W'(bus.out_valid), W'(0));
    check("mid_rst_state", W'(dbg_state), W'(FILL));
    check("mid_rst_n_w1", n_w1, Q_ONE);
    repeat (10) tick();
    check("mid_rst_quiet", W'(bus.out_valid), W'(0));
    bus.out_ready = 1'b0;
    send('0); send('0); send('0);
    wait_valid(20);
    check("post_rst_result", bus.out_data, HALF);
    bus.out_ready = 1'b1;
    wait_drain(50);
    check("final_partial", W'(part_n), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
